// File: rtl/fetch_stage_pkg.sv
// Shared fetch/decode constants: memory geometry, reset PC, bubble word and opcode field helpers.
package fetch_stage_pkg;

  localparam int          MEM_DEPTH    = 256;
  localparam int          ADDR_W       = $clog2(MEM_DEPTH);
  localparam logic [31:0] RESET_PC     = 32'd0;
  localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0000;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;

  localparam logic [5:0] OP_ADD  = 6'h00;
  localparam logic [5:0] OP_JUMP = 6'h02;
  localparam logic [5:0] OP_LW   = 6'h23;

  function automatic logic [5:0] opcode_of(input logic [31:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: captures {instr, pc, pc_plus1, valid}; flush inserts a bubble, else hold.
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] BUBBLE = BUBBLE_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] d_instr,
  input  logic [31:0] d_pc,
  input  logic [31:0] d_pc_plus1,
  output logic [31:0] q_instr,
  output logic [31:0] q_pc,
  output logic [31:0] q_pc_plus1,
  output logic        q_valid
);

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_instr    <= BUBBLE;
      q_pc       <= '0;
      q_pc_plus1 <= '0;
      q_valid    <= 1'b0;
    end else if (flush) begin
      // A flushed slot keeps its pc fields; only the instruction and valid bit are squashed.
      q_instr <= BUBBLE;
      q_valid <= 1'b0;
    end else if (load) begin
      q_instr    <= d_instr;
      q_pc       <= d_pc;
      q_pc_plus1 <= d_pc_plus1;
      q_valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, next-PC wrap, redirect/stall priority and the saturating fetch counter.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int          MEM_DEPTH_P    = MEM_DEPTH,
  parameter int          ADDR_W_P       = ADDR_W,
  parameter logic [31:0] RESET_PC_P     = RESET_PC,
  parameter logic [31:0] BUBBLE_INSTR_P = BUBBLE_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus1,
  output logic        ifid_valid,
  output logic [31:0] fetch_count
);

  logic [31:0] pc_q;
  logic [31:0] next_pc;
  logic [31:0] redirect_target;
  logic        advance;
  logic        unused_redirect_hi;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    next_pc = pc_q + 32'd1;
    if (pc_q[ADDR_W_P-1:0] == ADDR_W_P'(MEM_DEPTH_P - 1))
      next_pc = '0;
  end

  // Redirect targets are word indices; bits above the memory range are dropped silently.
  assign redirect_target    = 32'(redirect_pc[ADDR_W_P-1:0]);
  assign unused_redirect_hi = ^redirect_pc[31:ADDR_W_P];

  assign advance = !redirect_valid && !stall;
  assign imem_pc = pc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q        <= RESET_PC_P;
      fetch_count <= '0;
    end else if (redirect_valid) begin
      pc_q <= redirect_target;
    end else if (advance) begin
      pc_q <= next_pc;
      if (fetch_count != 32'hFFFF_FFFF)
        fetch_count <= fetch_count + 32'd1;
    end
  end

  if_id_reg #(
    .BUBBLE (BUBBLE_INSTR_P)
  ) u_if_id_reg (
    .clk        (clk),
    .reset      (reset),
    .load       (advance),
    .flush      (redirect_valid),
    .d_instr    (imem_instr),
    .d_pc       (pc_q),
    .d_pc_plus1 (next_pc),
    .q_instr    (ifid_instr),
    .q_pc       (ifid_pc),
    .q_pc_plus1 (ifid_pc_plus1),
    .q_valid    (ifid_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a 256-word program memory where mem[i] = 32'hC0DE_0000 | i.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_pc;
  logic [31:0] imem_instr;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_plus1;
  logic        ifid_valid;
  logic [31:0] fetch_count;

  logic [31:0] mem [256];
  logic [7:0]  mem_idx;
  logic        unused_pc_hi;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign mem_idx      = imem_pc[7:0];
  assign unused_pc_hi = |imem_pc[31:8];
  assign imem_instr   = mem[mem_idx];

  fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_pc        (imem_pc),
    .imem_instr     (imem_instr),
    .ifid_instr     (ifid_instr),
    .ifid_pc        (ifid_pc),
    .ifid_pc_plus1  (ifid_pc_plus1),
    .ifid_valid     (ifid_valid),
    .fetch_count    (fetch_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle 1 time unit before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] pc, input logic [31:0] pc1,
                            input logic [31:0] instr, input logic valid);
    check({tag, ".ifid_pc"}, ifid_pc, pc);
    check({tag, ".ifid_pc_plus1"}, ifid_pc_plus1, pc1);
    check({tag, ".ifid_instr"}, ifid_instr, instr);
    check({tag, ".ifid_valid"}, 32'(ifid_valid), 32'(valid));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | 32'(i);

    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    #2;
    check("rst.imem_pc", imem_pc, 32'd0);
    check("rst.fetch_count", fetch_count, 32'd0);
    check_ifid("rst", 32'd0, 32'd0, 32'h0000_0000, 1'b0);

    step();
    reset = 1'b0;
    check("pre_edge.ifid_valid", 32'(ifid_valid), 32'd0);

    // Free run: five edges fetch words 0..4.
    step(); check_ifid("run0", 32'd0, 32'd1, 32'hC0DE_0000, 1'b1);
    step(); check_ifid("run1", 32'd1, 32'd2, 32'hC0DE_0001, 1'b1);
    step(); check_ifid("run2", 32'd2, 32'd3, 32'hC0DE_0002, 1'b1);
    step(); check_ifid("run3", 32'd3, 32'd4, 32'hC0DE_0003, 1'b1);
    step(); check_ifid("run4", 32'd4, 32'd5, 32'hC0DE_0004, 1'b1);
    check("run.fetch_count", fetch_count, 32'd5);
    check("run.imem_pc", imem_pc, 32'd5);

    // Stall three cycles: everything holds.
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check("stall.imem_pc", imem_pc, 32'd5);
      check("stall.ifid_pc", ifid_pc, 32'd4);
      check("stall.fetch_count", fetch_count, 32'd5);
    end
    stall = 1'b0;
    step(); check_ifid("unstall", 32'd5, 32'd6, 32'hC0DE_0005, 1'b1);
    check("unstall.fetch_count", fetch_count, 32'd6);
    step(); check("pre_redir.imem_pc", imem_pc, 32'd7);

    // Redirect to 20 while pc_q = 7.
    redirect_valid = 1'b1; redirect_pc = 32'd20;
    step();
    redirect_valid = 1'b0;
    check("redir.imem_pc", imem_pc, 32'd20);
    check_ifid("redir", 32'd6, 32'd7, 32'h0000_0000, 1'b0);
    check("redir.fetch_count", fetch_count, 32'd7);
    step(); check_ifid("redir_next", 32'd20, 32'd21, 32'hC0DE_0014, 1'b1);
    check("redir_next.fetch_count", fetch_count, 32'd8);

    // Redirect and stall together: redirect wins, upper target bits masked.
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0105;
    step();
    stall = 1'b0; redirect_valid = 1'b0;
    check("both.imem_pc", imem_pc, 32'd5);
    check("both.ifid_valid", 32'(ifid_valid), 32'd0);
    check("both.fetch_count", fetch_count, 32'd8);
    step(); check_ifid("both_next", 32'd5, 32'd6, 32'hC0DE_0005, 1'b1);

    // Wrap: redirect to 250 then run through 255.
    redirect_valid = 1'b1; redirect_pc = 32'd250;
    step();
    redirect_valid = 1'b0;
    check("wrap.redir_pc", imem_pc, 32'd250);
    for (int c = 0; c < 5; c++) step();
    check("wrap.pre_imem_pc", imem_pc, 32'd255);
    step();
    check_ifid("wrap", 32'd255, 32'd0, 32'hC0DE_00FF, 1'b1);
    check("wrap.imem_pc", imem_pc, 32'd0);
    check("wrap.fetch_count", fetch_count, 32'd15);
    step();
    check_ifid("wrap_next", 32'd0, 32'd1, 32'hC0DE_0000, 1'b1);
    check("wrap_next.fetch_count", fetch_count, 32'd16);

    // Async reset between edges at pc_q = 12.
    redirect_valid = 1'b1; redirect_pc = 32'd10;
    step();
    redirect_valid = 1'b0;
    step(); step();
    check("mid.imem_pc", imem_pc, 32'd12);
    check("mid.fetch_count", fetch_count, 32'd18);
    #3 reset = 1'b1;
    #1;
    check("async.imem_pc", imem_pc, 32'd0);
    check("async.fetch_count", fetch_count, 32'd0);
    check_ifid("async", 32'd0, 32'd0, 32'h0000_0000, 1'b0);
    #2 reset = 1'b0;
    step();
    check_ifid("resume", 32'd0, 32'd1, 32'hC0DE_0000, 1'b1);
    check("resume.fetch_count", fetch_count, 32'd1);
    check("resume.imem_pc", imem_pc, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
